// File: rtl/permute_ctrl_pkg.sv
// rtl/permute_ctrl_pkg.sv - shared constants for the permutation sequencing controller
// Holds the binary state encoding and the default CNT_W / N_ITER / CALC_STAGES values.
package permute_ctrl_pkg;

    localparam int DEF_CNT_W       = 6;
    localparam int DEF_N_ITER      = 64;
    localparam int DEF_CALC_STAGES = 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_INIT = 3'd1;
    localparam state_t S_LOAD = 3'd2;
    localparam state_t S_CALC = 3'd3;
    localparam state_t S_OUT  = 3'd4;
    localparam state_t S_DONE = 3'd5;

endpackage

// File: rtl/permute_seq_ctrl_if.sv
// rtl/permute_seq_ctrl_if.sv - control/status bundle between sequencer and its environment
// master: drives start, abort, in_valid, out_ack; observes the datapath strobes and status.
// slave:  the sequencer; drives sel, ld, read, out_valid, busy, done, total_ready,
//         iter_idx (CNT_W bits) and stage_idx (3 bits).
interface permute_seq_ctrl_if
    import permute_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             out_ack;
    logic             sel;
    logic             ld;
    logic             read;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             total_ready;
    logic [CNT_W-1:0] iter_idx;
    logic [2:0]       stage_idx;

    modport master (
        output start, abort, in_valid, out_ack,
        input  sel, ld, read, out_valid, busy, done, total_ready, iter_idx, stage_idx
    );

    modport slave (
        input  start, abort, in_valid, out_ack,
        output sel, ld, read, out_valid, busy, done, total_ready, iter_idx, stage_idx
    );
endinterface

// File: rtl/permute_iter_counter.sv
// rtl/permute_iter_counter.sv - up-counter with sync clear/increment and terminal-count flag
// Ports: clk, rst (async, active-high), clr (sync clear, wins over inc), inc,
//        count (W bits), at_term (count == TERM).
module permute_iter_counter #(
    parameter int           W    = 6,
    parameter logic [W-1:0] TERM = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign at_term = (count == TERM);

endmodule

// File: rtl/permute_seq_ctrl.sv
// rtl/permute_seq_ctrl.sv - sequencing controller stepping the permute datapath through N_ITER slices
// Ports: clk, rst (async, active-high), bus (permute_seq_ctrl_if.slave):
//        start/abort/in_valid/out_ack in; sel/ld/read/out_valid/busy/done/total_ready,
//        iter_idx, stage_idx out.
module permute_seq_ctrl
    import permute_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int N_ITER      = DEF_N_ITER,
    parameter int CALC_STAGES = DEF_CALC_STAGES,
    parameter int HOLD_OUT    = 1
) (
    input logic                clk,
    input logic                rst,
    permute_seq_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] ITER_TERM = CNT_W'(N_ITER - 1);
    localparam logic [2:0]       STG_TERM  = 3'(CALC_STAGES - 1);
    localparam logic             HOLD      = (HOLD_OUT != 0);

    state_t           state;
    state_t           state_nxt;
    logic             iter_clr;
    logic             iter_inc;
    logic             iter_term;
    logic [CNT_W-1:0] iter_cnt;
    logic             stg_clr;
    logic             stg_inc;
    logic             stg_term;
    logic [2:0]       stg_cnt;
    logic             out_hs;

    // Without HOLD the result is presented for exactly one cycle, so every OUT cycle handshakes.
    assign out_hs = bus.out_ack || !HOLD;

    always_comb begin
        state_nxt = state;
        iter_clr  = 1'b0;
        iter_inc  = 1'b0;
        stg_clr   = 1'b0;
        stg_inc   = 1'b0;
        if (state != S_IDLE && bus.abort) begin
            state_nxt = S_IDLE;
            iter_clr  = 1'b1;
            stg_clr   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_nxt = S_INIT;
                    end
                end
                S_INIT: begin
                    iter_clr  = 1'b1;
                    stg_clr   = 1'b1;
                    state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        state_nxt = S_CALC;
                    end
                end
                S_CALC: begin
                    if (stg_term) begin
                        stg_clr   = 1'b1;
                        state_nxt = S_OUT;
                    end else begin
                        stg_inc = 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        if (iter_term) begin
                            state_nxt = S_DONE;
                        end else begin
                            iter_inc  = 1'b1;
                            state_nxt = S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    permute_iter_counter #(
        .W    (CNT_W),
        .TERM (ITER_TERM)
    ) u_iter_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (iter_clr),
        .inc     (iter_inc),
        .count   (iter_cnt),
        .at_term (iter_term)
    );

    permute_iter_counter #(
        .W    (3),
        .TERM (STG_TERM)
    ) u_stg_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (stg_clr),
        .inc     (stg_inc),
        .count   (stg_cnt),
        .at_term (stg_term)
    );

    // A stalled LOAD must neither pop the source nor clobber the datapath register.
    assign bus.sel         = (state == S_CALC);
    assign bus.read        = (state == S_LOAD) && bus.in_valid;
    assign bus.ld          = (state == S_CALC) || bus.read;
    assign bus.out_valid   = (state == S_OUT);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.total_ready = (state == S_IDLE);
    assign bus.iter_idx    = iter_cnt;
    assign bus.stage_idx   = stg_cnt;

endmodule
